otter_iobus_uart_tx: RTL and testbench
======================================

# otter_iobus_uart_tx

Memory-mapped UART transmitter that responds on the OTTER IOBUS (the peripheral end of CPU_IOBUS_ADDR/OUT/WR/IN). It decodes CPU stores into a 4-register window, queues bytes in an 8-entry TX FIFO, serialises them as 8N1 frames on a TX pin, and returns register contents to CPU_IOBUS_IN for loads. It sits in the top-level wrapper beside other IOBUS peripherals.

## Interface
- BASE_ADDR, 32'h1100_0100, word-aligned 16-byte window base
- DEFAULT_DIV, 16'd868, reset value of BAUD_DIV (clocks per bit)
- FIFO_DEPTH, 8, TX FIFO entries, power of two
- IO_CLK  in  1  system clock, same as CPU_CLK
- IO_RST_N  in  1  reset, asynchronous assert, active-low
- IO_ADDR  in  32  from CPU_IOBUS_ADDR
- IO_WR_DATA  in  32  from CPU_IOBUS_OUT
- IO_WR  in  1  from CPU_IOBUS_WR, one-cycle store strobe
- IO_RD_DATA  out  32  to CPU_IOBUS_IN, combinational read of decoded register
- UART_TX  out  1  serial line, idle high
- TX_IRQ  out  1  level interrupt request

## Operation
- Select: hit = IO_ADDR[31:4]==BASE_ADDR[31:4]; IO_ADDR[3:2] picks register; IO_ADDR[1:0] ignored; whole-word access only.
- 0x0 TXDATA (W): push IO_WR_DATA[7:0]. Reads 0.
- 0x4 STATUS (R): [0] empty, [1] full, [2] busy (state≠IDLE), [3] overflow (sticky), [7:4] count (0..8), rest 0. W: writing 1 to bit 3 clears overflow; other bits ignored.
- 0x8 BAUD_DIV (RW): [15:0]; reads zero-extended. Value 0 treated as 1.
- 0xC CTRL (RW): [0] tx_en (reset 0), [1] irq_en (reset 0).
- Miss or unmapped read: IO_RD_DATA=0; miss write: no effect.
- Push when full with no pop same cycle: byte dropped, overflow set. Push and pop same cycle when full: push accepted, count stays 8.
- FSM IDLE -> START -> DATA -> STOP -> (START | IDLE).
  - IDLE: UART_TX=1; if tx_en && !empty: pop head into shift reg, latch BAUD_DIV into bit_div, go START.
  - START: UART_TX=0 for bit_div clocks.
  - DATA: 8 bits LSB first, bit_div clocks each; 3-bit bit index.
  - STOP: UART_TX=1 for bit_div clocks; at end, if tx_en && !empty pop and go START directly (back-to-back frames), else IDLE.
- BAUD_DIV write mid-frame affects next frame only. Clearing tx_en mid-frame: current frame completes, no further pops.
- TX_IRQ = irq_en && empty && state==IDLE.
- Baud counter 16-bit, counts bit_div-1 down to 0; bit boundary when 0.

## Timing
- Reset (async, IO_RST_N=0): UART_TX=1, TX_IRQ=0, FIFO empty, pointers 0, overflow 0, CTRL 0, BAUD_DIV=DEFAULT_DIV, FSM IDLE; IO_RD_DATA reflects reset registers. Reset mid-frame aborts immediately, line high.
- Register writes take effect at the IO_CLK edge where IO_WR=1.
- Read path combinational; value sampled by CPU memory at the load's MEM edge.
- Latency: push at edge N into empty FIFO with tx_en=1 -> pop at edge N+1, UART_TX falls after edge N+1.
- Frame = exactly 10*bit_div clocks; back-to-back frames have no idle gap.
- STATUS.count updates the edge after push/pop.

## Structure
- Package otter_io_pkg: register offsets (TXDATA/STATUS/BAUD/CTRL), STATUS bit positions, FSM enum uart_tx_state_t {IDLE, START, DATA, STOP}, IOBUS base constants.
- Sub-module sync_fifo (parameterised width/depth, count output, simultaneous push/pop), instantiated with width 8.
- Top contains decode, registers, baud counter, FSM.

## Test plan
- Reset then read 0x4 -> 32'h0000_0001; read 0x8 -> 868; UART_TX=1; TX_IRQ=0.
- BAUD_DIV=4, CTRL=1, write 0x55 -> UART_TX 0,1,0,1,0,1,0,1,0,1 each 4 clocks (40 total), then STATUS busy=0, empty=1.
- CTRL=0, write 9 bytes -> STATUS=32'h0000_008A (count 8, full, overflow); write 0x8 to STATUS -> overflow 0; set tx_en -> exactly 8 frames, back-to-back, 80*div clocks.
- BAUD_DIV=2, send 0xA5, write BAUD_DIV=6 mid-frame -> that frame stays 20 clocks, next frame 60 clocks.
- CTRL=3, one byte -> TX_IRQ low during frame, high one cycle after STOP ends; read of 0x1100_0110 (miss) -> 0.
- Assert IO_RST_N during DATA bit 3 -> UART_TX=1 immediately, FIFO empty, BAUD_DIV=868 after release.

Source files
------------

// File: rtl/otter_iobus_uart_tx_pkg.sv
// otter_io_pkg
//   Shared constants for the OTTER IOBUS UART transmitter: register offsets
//   inside the 16-byte window, STATUS/CTRL bit positions, the IOBUS base
//   address of the peripheral and the transmitter state encoding.
package otter_io_pkg;

  // Default IOBUS window base (word-aligned, 16 bytes)
  localparam logic [31:0] IOBUS_UART_BASE = 32'h1100_0100;
  localparam logic [15:0] IOBUS_UART_DEFAULT_DIV = 16'd868;
  localparam int          IOBUS_UART_FIFO_DEPTH  = 8;

  // Register select values taken from IO_ADDR[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int STAT_EMPTY     = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_BUSY      = 2;
  localparam int STAT_OVF       = 3;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_W   = 4;

  // CTRL bit positions
  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/otter_iobus_uart_tx_if.sv
// otter_iobus_uart_tx_if
//   Peripheral end of the OTTER IOBUS.
//   IO_ADDR    : CPU_IOBUS_ADDR
//   IO_WR_DATA : CPU_IOBUS_OUT
//   IO_WR      : CPU_IOBUS_WR, one-cycle store strobe
//   IO_RD_DATA : CPU_IOBUS_IN, combinational read data from the peripheral
//   master = CPU side, slave = peripheral side.
interface otter_iobus_uart_tx_if;
  logic [31:0] IO_ADDR;
  logic [31:0] IO_WR_DATA;
  logic        IO_WR;
  logic [31:0] IO_RD_DATA;

  modport master (
    output IO_ADDR,
    output IO_WR_DATA,
    output IO_WR,
    input  IO_RD_DATA
  );

  modport slave (
    input  IO_ADDR,
    input  IO_WR_DATA,
    input  IO_WR,
    output IO_RD_DATA
  );
endinterface

// File: rtl/otter_iobus_uart_tx_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with occupancy count. The head entry is always visible
//   on pop_data. A push while full is accepted only when a pop happens in the
//   same cycle; a pop while empty is ignored.
//   clk, rst_n        : clock, asynchronous active-low reset
//   push, push_data   : write request and data
//   pop, pop_data     : read request, head-of-queue data
//   count             : entries held (0..DEPTH)
//   empty, full       : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign empty    = (count_q == CNT_W'(0));
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Popping frees a slot in the same cycle, so a full FIFO can still take a push
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible through count
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/otter_iobus_uart_tx.sv
// otter_iobus_uart_tx
//   Memory-mapped 8N1 UART transmitter on the OTTER IOBUS. Stores into the
//   16-byte window at BASE_ADDR write TXDATA/STATUS/BAUD_DIV/CTRL; loads return
//   the decoded register combinationally. Bytes are queued in a TX FIFO and
//   shifted out LSB first, BAUD_DIV clocks per bit.
//   IO_CLK, IO_RST_N : system clock, asynchronous active-low reset
//   iobus            : IOBUS slave port (address, write data, strobe, read data)
//   UART_TX          : serial output, idle high
//   TX_IRQ           : level interrupt, irq_en && FIFO empty && transmitter idle
module otter_iobus_uart_tx
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IOBUS_UART_BASE,
  parameter logic [15:0] DEFAULT_DIV = IOBUS_UART_DEFAULT_DIV,
  parameter int          FIFO_DEPTH  = IOBUS_UART_FIFO_DEPTH
) (
  input  logic                   IO_CLK,
  input  logic                   IO_RST_N,
  otter_iobus_uart_tx_if.slave   iobus,
  output logic                   UART_TX,
  output logic                   TX_IRQ
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  uart_tx_state_t state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [15:0]    baud_cnt_q, baud_cnt_d;
  logic [15:0]    bit_div_q, bit_div_d;
  logic [15:0]    baud_div_q, baud_div_d;
  logic           tx_en_q, tx_en_d;
  logic           irq_en_q, irq_en_d;
  logic           ovf_q, ovf_d;

  logic             hit;
  logic [1:0]       reg_sel;
  logic             wr_txdata, wr_status, wr_baud, wr_ctrl;
  logic             fifo_pop;
  logic [7:0]       fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty, fifo_full;
  logic [15:0]      eff_div;
  logic             bit_done;
  logic             load_frame;
  logic [31:0]      rd_data;
  logic             unused_bits;

  assign hit       = (iobus.IO_ADDR[31:4] == BASE_ADDR[31:4]);
  assign reg_sel   = iobus.IO_ADDR[3:2];
  assign wr_txdata = iobus.IO_WR && hit && (reg_sel == REG_TXDATA);
  assign wr_status = iobus.IO_WR && hit && (reg_sel == REG_STATUS);
  assign wr_baud   = iobus.IO_WR && hit && (reg_sel == REG_BAUD);
  assign wr_ctrl   = iobus.IO_WR && hit && (reg_sel == REG_CTRL);

  assign unused_bits = ^{iobus.IO_WR_DATA[31:16], iobus.IO_ADDR[1:0]};

  // A divider of 0 would never produce a bit boundary, so it runs as 1
  assign eff_div  = (baud_div_q == 16'd0) ? 16'd1 : baud_div_q;
  assign bit_done = (baud_cnt_q == 16'd0);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (IO_CLK),
    .rst_n     (IO_RST_N),
    .push      (wr_txdata),
    .push_data (iobus.IO_WR_DATA[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Software-visible registers. Overflow is only flagged when the push is
  // really dropped, i.e. the FIFO is full and the transmitter is not popping.
  always_comb begin
    baud_div_d = baud_div_q;
    tx_en_d    = tx_en_q;
    irq_en_d   = irq_en_q;
    ovf_d      = ovf_q;
    if (wr_baud) begin
      baud_div_d = iobus.IO_WR_DATA[15:0];
    end
    if (wr_ctrl) begin
      tx_en_d  = iobus.IO_WR_DATA[CTRL_TX_EN];
      irq_en_d = iobus.IO_WR_DATA[CTRL_IRQ_EN];
    end
    if (wr_status && iobus.IO_WR_DATA[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
    if (wr_txdata && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
  end

  // Transmit FSM. Each of START, the eight DATA bits and STOP lasts bit_div
  // clocks: the baud counter is loaded with bit_div-1 and the boundary is the
  // cycle it reads 0. A frame load (from IDLE or at the end of STOP) pops the
  // head and captures BAUD_DIV, so divider writes only affect later frames.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    baud_cnt_d = baud_cnt_q;
    bit_div_d  = bit_div_q;
    load_frame = 1'b0;
    fifo_pop   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tx_en_q && !fifo_empty) begin
          load_frame = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d    = DATA;
          bit_idx_d  = 3'd0;
          baud_cnt_d = bit_div_q - 16'd1;
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          baud_cnt_d = bit_div_q - 16'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (tx_en_q && !fifo_empty) begin
            load_frame = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_frame) begin
      fifo_pop   = 1'b1;
      shift_d    = fifo_head;
      bit_div_d  = eff_div;
      baud_cnt_d = eff_div - 16'd1;
      state_d    = START;
    end
  end

  always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
    if (!IO_RST_N) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      baud_cnt_q <= '0;
      bit_div_q  <= DEFAULT_DIV;
      baud_div_q <= DEFAULT_DIV;
      tx_en_q    <= 1'b0;
      irq_en_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      baud_cnt_q <= baud_cnt_d;
      bit_div_q  <= bit_div_d;
      baud_div_q <= baud_div_d;
      tx_en_q    <= tx_en_d;
      irq_en_q   <= irq_en_d;
      ovf_q      <= ovf_d;
    end
  end

  // The line is decoded from registered state so reset forces it high at once
  always_comb begin
    UART_TX = 1'b1;
    unique case (state_q)
      START:   UART_TX = 1'b0;
      DATA:    UART_TX = shift_q[0];
      default: UART_TX = 1'b1;
    endcase
  end

  assign TX_IRQ = irq_en_q && fifo_empty && (state_q == IDLE);

  always_comb begin
    rd_data = '0;
    if (hit) begin
      unique case (reg_sel)
        REG_STATUS: begin
          rd_data[STAT_EMPTY] = fifo_empty;
          rd_data[STAT_FULL]  = fifo_full;
          rd_data[STAT_BUSY]  = (state_q != IDLE);
          rd_data[STAT_OVF]   = ovf_q;
          rd_data[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
        end
        REG_BAUD: begin
          rd_data[15:0] = baud_div_q;
        end
        REG_CTRL: begin
          rd_data[CTRL_TX_EN]  = tx_en_q;
          rd_data[CTRL_IRQ_EN] = irq_en_q;
        end
        default: begin
          rd_data = '0;
        end
      endcase
    end
  end

  assign iobus.IO_RD_DATA = rd_data;

endmodule

// File: tb/tb_otter_iobus_uart_tx.sv
// tb_otter_iobus_uart_tx
//   Scoreboard bench: every accepted byte is queued with the bit period it
//   should go out at; an independent line monitor recovers frames from
//   UART_TX and compares them sample-by-sample against the queue head.
module tb_otter_iobus_uart_tx;

  localparam logic [31:0] BASE     = 32'h1100_0100;
  localparam logic [31:0] A_TXDATA = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_BAUD   = BASE + 32'h8;
  localparam logic [31:0] A_CTRL   = BASE + 32'hC;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_tx;
  logic tx_irq;

  int vectors = 0;
  int miscompares = 0;
  int cycle_cnt = 0;

  frame_t exp_q[$];
  int     frame_starts[$];

  int  mdl_count;
  bit  mdl_ovf;
  bit  mdl_tx_en;

  otter_iobus_uart_tx_if bus();

  otter_iobus_uart_tx #(
    .BASE_ADDR   (BASE),
    .DEFAULT_DIV (16'd868),
    .FIFO_DEPTH  (8)
  ) dut (
    .IO_CLK   (clk),
    .IO_RST_N (rst_n),
    .iobus    (bus),
    .UART_TX  (uart_tx),
    .TX_IRQ   (tx_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #500us;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.IO_ADDR    = a;
    bus.IO_WR_DATA = d;
    bus.IO_WR      = 1'b1;
    @(posedge clk);
    #1;
    bus.IO_WR = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.IO_ADDR = a;
    #1;
    d = bus.IO_RD_DATA;
  endtask

  task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    busRead(a, v);
    checkOutput(name, v, exp);
  endtask

  // STATUS as seen while the transmitter is idle, from the model's occupancy
  function automatic logic [31:0] idleStatus();
    logic [31:0] s;
    s = 32'(mdl_count) << 4;
    if (mdl_count == 0) s = s | 32'h1;
    if (mdl_count == 8) s = s | 32'h2;
    if (mdl_ovf)        s = s | 32'h8;
    return s;
  endfunction

  // Push one byte; the model decides if it is kept and queues the expected frame
  task automatic applyStimulus(input logic [7:0] b, input int div);
    if (mdl_count < 8) begin
      exp_q.push_back('{data: b, div: div});
      if (!mdl_tx_en) mdl_count++;
    end else begin
      mdl_ovf = 1'b1;
    end
    busWrite(A_TXDATA, {24'h0, b});
  endtask

  task automatic waitIdle(input int budget);
    logic [31:0] st;
    int k;
    for (k = 0; k < budget; k++) begin
      busRead(A_STATUS, st);
      if (st[2] == 1'b0 && st[0] == 1'b1) break;
    end
    checkOutput("wait_idle_in_budget", 32'(k < budget), 32'h1);
  endtask

  // Line monitor: a low sample while no frame is in progress is a start bit
  initial begin : monitor
    frame_t f;
    logic [7:0] rec;
    bit ok;
    bit aborted;
    int pos;
    logic want;
    forever begin
      @(negedge clk);
      if (rst_n && uart_tx === 1'b0) begin
        frame_starts.push_back(cycle_cnt);
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected_frame: got start bit at cycle %0d, required none", cycle_cnt);
          while (uart_tx === 1'b0 && rst_n) @(negedge clk);
        end else begin
          f = exp_q.pop_front();
          ok = 1'b1;
          aborted = 1'b0;
          rec = 8'h00;
          for (int s = 0; s < 10 * f.div; s++) begin
            if (s > 0) @(negedge clk);
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            pos = s / f.div;
            if (pos == 0)      want = 1'b0;
            else if (pos == 9) want = 1'b1;
            else               want = f.data[pos-1];
            if (uart_tx !== want) ok = 1'b0;
            if (pos >= 1 && pos <= 8 && (s % f.div) == f.div / 2) rec[pos-1] = uart_tx;
          end
          if (!aborted) begin
            vectors++;
            if (!ok) begin
              miscompares++;
              $display("[TB] FAIL frame: got byte 0x%02h (or bad bit timing), required 0x%02h at %0d clocks/bit",
                       rec, f.data, f.div);
            end
          end
        end
      end
    end
  end

  initial begin : main
    int div;
    int n0;
    int first_k;
    logic [7:0] b;

    bus.IO_ADDR    = '0;
    bus.IO_WR_DATA = '0;
    bus.IO_WR      = 1'b0;
    mdl_count = 0;
    mdl_ovf   = 1'b0;
    mdl_tx_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    readCheck("reset_status", A_STATUS, 32'h0000_0001);
    readCheck("reset_baud", A_BAUD, 32'd868);
    readCheck("reset_ctrl", A_CTRL, 32'h0);
    checkOutput("reset_uart_tx", 32'(uart_tx), 32'h1);
    checkOutput("reset_irq", 32'(tx_irq), 32'h0);

    // Single frame 0x55 at 4 clocks/bit, with push-to-start latency
    busWrite(A_BAUD, 32'd4);
    busWrite(A_CTRL, 32'h1);
    mdl_tx_en = 1'b1;
    applyStimulus(8'h55, 4);
    checkOutput("tx_high_at_push_edge", 32'(uart_tx), 32'h1);
    @(posedge clk);
    #1;
    checkOutput("tx_low_after_pop_edge", 32'(uart_tx), 32'h0);
    waitIdle(200);
    readCheck("status_after_frame", A_STATUS, 32'h0000_0001);

    // Fill with tx disabled, overflow, clear, then burst of 8 frames
    div = $urandom_range(2, 5);
    busWrite(A_CTRL, 32'h0);
    mdl_tx_en = 1'b0;
    busWrite(A_BAUD, 32'(div));
    for (int i = 0; i < 9; i++) applyStimulus(8'($urandom), div);
    readCheck("status_full_ovf", A_STATUS, idleStatus());
    busWrite(A_STATUS, 32'h8);
    mdl_ovf = 1'b0;
    readCheck("status_ovf_cleared", A_STATUS, idleStatus());
    n0 = frame_starts.size();
    busWrite(A_CTRL, 32'h1);
    mdl_tx_en = 1'b1;
    mdl_count = 0;
    waitIdle(1000);
    checkOutput("burst_frame_count", 32'(frame_starts.size() - n0), 32'd8);
    if (frame_starts.size() == n0 + 8)
      checkOutput("burst_back_to_back", 32'(frame_starts[n0+7] - frame_starts[n0]), 32'(70 * div));

    // Divider change mid-frame applies to the following frame only
    busWrite(A_BAUD, 32'd2);
    n0 = frame_starts.size();
    applyStimulus(8'hA5, 2);
    repeat (5) @(posedge clk);
    busWrite(A_BAUD, 32'd6);
    applyStimulus(8'($urandom), 6);
    waitIdle(300);
    checkOutput("divchg_frame_count", 32'(frame_starts.size() - n0), 32'd2);
    if (frame_starts.size() == n0 + 2)
      checkOutput("divchg_first_frame_len", 32'(frame_starts[n0+1] - frame_starts[n0]), 32'd20);

    // Interrupt timing and address decode
    busWrite(A_BAUD, 32'd3);
    busWrite(A_CTRL, 32'h3);
    readCheck("ctrl_readback", A_CTRL, 32'h3);
    checkOutput("irq_idle_enabled", 32'(tx_irq), 32'h1);
    applyStimulus(8'($urandom), 3);
    checkOutput("irq_low_after_push", 32'(tx_irq), 32'h0);
    first_k = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (tx_irq === 1'b1) begin
        first_k = k;
        break;
      end
    end
    checkOutput("irq_rise_cycle", 32'(first_k), 32'd31);
    readCheck("miss_read", 32'h1100_0110, 32'h0);
    busWrite(32'h1100_0118, 32'h0);
    readCheck("miss_write_no_effect", A_CTRL, 32'h3);
    readCheck("txdata_reads_zero", A_TXDATA, 32'h0);
    readCheck("low_addr_bits_ignored", A_STATUS | 32'h3, 32'h0000_0001);

    // Reset during DATA bit 3
    busWrite(A_CTRL, 32'h1);
    busWrite(A_BAUD, 32'd4);
    b = 8'($urandom);
    applyStimulus(b, 4);
    repeat (18) @(posedge clk);
    #1;
    checkOutput("line_in_data_bit3", 32'(uart_tx), 32'(b[3]));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_forces_line_high", 32'(uart_tx), 32'h1);
    checkOutput("reset_irq_low", 32'(tx_irq), 32'h0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    mdl_count = 0;
    mdl_ovf   = 1'b0;
    mdl_tx_en = 1'b0;
    readCheck("post_reset_status", A_STATUS, 32'h0000_0001);
    readCheck("post_reset_baud", A_BAUD, 32'd868);
    readCheck("post_reset_ctrl", A_CTRL, 32'h0);
    repeat (10) @(posedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
